// File: rtl/branch_redirect.sv
// branch_redirect
//   Fetch PC generator with EX-stage branch/jump redirect handling.
//   A taken branch resolved in EX either redirects the PC at once or, if
//   fetch is stalled, is parked until the stall clears. The cycle after a
//   redirect is applied is a squash cycle in which EX is ignored.
//
//   State table
//     state     | meaning
//     ----------+-----------------------------------------------------------
//     ST_RUN    | normal fetch; a taken EX branch is acted on here only
//     ST_PEND   | taken redirect parked in pend_pc_q, waiting for stall low
//     ST_SQUASH | one cycle after a redirect; EX holds a wrong-path op
//
// Ports
//   clk              in   clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   stall            in   fetch stall, PC holds
//   halt             in   HALT retired, PC freezes (dominates stall)
//   ex_valid         in   EX holds a real instruction
//   ex_brchcnd       in   EX taken/jump decision
//   ex_target[15:0]  in   resolved target address
//   pc[15:0]         out  current fetch address
//   flush            out  squash IF/ID and ID/EX this cycle
//   redirect_pending out  a taken redirect is parked
//   redirect_cnt[7:0]out  number of redirects applied (wraps)
module branch_redirect (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        halt,
  input  logic        ex_valid,
  input  logic        ex_brchcnd,
  input  logic [15:0] ex_target,
  output logic [15:0] pc,
  output logic        flush,
  output logic        redirect_pending,
  output logic [7:0]  redirect_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PEND   = 2'd1,
    ST_SQUASH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] pend_pc_q, pend_pc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        flush_d;

  logic        advance;
  logic        take;
  logic [15:0] tgt_aligned;
  logic [15:0] pc_inc;

  assign advance     = ~stall & ~halt;
  assign take        = ex_valid & ex_brchcnd;
  // Instructions are halfword aligned; the target LSB is dropped.
  assign tgt_aligned = ex_target & 16'hFFFE;
  assign pc_inc      = pc_q + 16'd2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      pc_q      <= 16'h0000;
      pend_pc_q <= 16'h0000;
      cnt_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    cnt_d     = cnt_q;
    flush_d   = 1'b0;
    case (state_q)
      ST_RUN: begin
        // halt blocks any redirect; the branch is simply not taken up.
        if (take && !halt) begin
          flush_d = 1'b1;
          if (!stall) begin
            pc_d    = tgt_aligned;
            cnt_d   = cnt_q + 8'd1;
            state_d = ST_SQUASH;
          end else begin
            pend_pc_d = tgt_aligned;
            state_d   = ST_PEND;
          end
        end else if (advance) begin
          pc_d = pc_inc;
        end
      end
      ST_PEND: begin
        if (advance) begin
          flush_d = 1'b1;
          pc_d    = pend_pc_q;
          cnt_d   = cnt_q + 8'd1;
          state_d = ST_SQUASH;
        end
      end
      ST_SQUASH: begin
        if (advance) begin
          pc_d = pc_inc;
        end
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // flush is combinational from EX inputs, so it is gated by reset to be
  // low the instant rst_n falls.
  assign flush            = flush_d & rst_n;
  assign redirect_pending = (state_q == ST_PEND);
  assign pc               = pc_q;
  assign redirect_cnt     = cnt_q;

endmodule
